stream_demux: RTL and testbench

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux.sv | 108 ++++++++++
 tb/tb_stream_demux.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// Valid/ready 1-to-N stream demultiplexer with one independent register slot per output channel.
// Define STREAM_DEMUX_CNT_EN to add the per-channel delivered-item counters (out_cnt).

module stream_demux_slot #(
    parameter int DATA_WIDTH = 32
`ifdef STREAM_DEMUX_CNT_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  cnt
`endif
);

    logic drain;

    assign drain = valid && ready;

    // Payload is cleared on drain so the output reads zero whenever the slot is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (drain) begin
            valid <= 1'b0;
            data  <= '0;
        end
    end

`ifdef STREAM_DEMUX_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (drain) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

module stream_demux #(
    parameter int CONTROL    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CONTROL-1:0]    in_sel,
    output logic                  out_valid [2**CONTROL],
    input  logic                  out_ready [2**CONTROL],
    output logic [DATA_WIDTH-1:0] out_data  [2**CONTROL]
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  out_cnt   [2**CONTROL]
`endif
);

    localparam int N = 2**CONTROL;

    logic accept;

    // Only the addressed slot gates acceptance, so a stalled channel never blocks the others.
    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < N; i++) begin : g_slot
        logic load;

        assign load = accept && (in_sel == CONTROL'(i));

        stream_demux_slot #(
            .DATA_WIDTH (DATA_WIDTH)
`ifdef STREAM_DEMUX_CNT_EN
            ,
            .CNT_WIDTH  (CNT_WIDTH)
`endif
        ) u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .din   (in_data),
            .ready (out_ready[i]),
            .valid (out_valid[i]),
            .data  (out_data[i])
`ifdef STREAM_DEMUX_CNT_EN
            ,
            .cnt   (out_cnt[i])
`endif
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// Randomised + directed bench for stream_demux; a queue-per-channel reference model is
// updated from observed handshakes and a monitor compares every channel each cycle.

module tb_stream_demux;

    localparam int CONTROL = 2;
    localparam int N       = 4;
    localparam int DW      = 32;
`ifdef STREAM_DEMUX_CNT_EN
    localparam int CW      = 4;
`else
    localparam int CW      = 16;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    in_sel = '0;
    logic          out_valid [N];
    logic          out_ready [N];
    logic [DW-1:0] out_data  [N];
`ifdef STREAM_DEMUX_CNT_EN
    logic [CW-1:0] out_cnt   [N];
`endif

    int compared = 0;
    int mismatched = 0;

    logic [DW-1:0] exp_q [N][$];
    int            cnt_m [N];

    stream_demux #(.CONTROL(CONTROL), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef STREAM_DEMUX_CNT_EN
        ,
        .out_cnt   (out_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor + reference model: a channel holds an item exactly when its queue is non-empty.
    always @(negedge clk) begin
        logic exp_rdy;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                exp_q[i].delete();
                cnt_m[i] = 0;
            end
        end else begin
            exp_rdy = (exp_q[in_sel].size() == 0) || out_ready[in_sel];
            chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
            for (int i = 0; i < N; i++) begin
                logic          v;
                logic [DW-1:0] d;
                v = exp_q[i].size() != 0;
                d = v ? exp_q[i][0] : '0;
                chk($sformatf("out_valid[%0d]", i), {63'd0, out_valid[i]}, {63'd0, v});
                chk($sformatf("out_data[%0d]", i), {32'd0, out_data[i]}, {32'd0, d});
`ifdef STREAM_DEMUX_CNT_EN
                chk($sformatf("out_cnt[%0d]", i), {60'd0, out_cnt[i]}, 64'(cnt_m[i]));
`endif
                if (v && out_ready[i]) begin
                    void'(exp_q[i].pop_front());
                    cnt_m[i] = (cnt_m[i] + 1) % (2**CW);
                end
            end
            if (in_valid && exp_rdy) exp_q[in_sel].push_back(in_data);
        end
    end

    task automatic drive(input logic v, input int sel, input logic [DW-1:0] d, input logic [N-1:0] rdy);
        @(posedge clk);
        #1;
        in_valid = v;
        in_sel   = sel[1:0];
        in_data  = d;
        for (int i = 0; i < N; i++) out_ready[i] = rdy[i];
    endtask

    initial begin
        for (int i = 0; i < N; i++) out_ready[i] = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        // Reset held two cycles while upstream keeps offering an item.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst out_valid[%0d]", i), {63'd0, out_valid[i]}, 64'd0);
            chk($sformatf("rst out_data[%0d]", i), {32'd0, out_data[i]}, 64'd0);
        end

        // Routing: one item per channel, all consumers ready.
        for (int k = 0; k < N; k++) drive(1'b1, k, 32'hA0 + 32'(k), 4'hF);
        drive(1'b0, 0, '0, 4'hF);
        drive(1'b0, 0, '0, 4'hF);

        // Backpressure on channel 2.
        drive(1'b1, 2, 32'h11, 4'b1011);
        drive(1'b1, 2, 32'h22, 4'b1011);
        @(negedge clk);
        chk("bp in_ready held low", {63'd0, in_ready}, 64'd0);
        chk("bp data held", {32'd0, out_data[2]}, 64'h11);
        drive(1'b1, 2, 32'h22, 4'b1011);
        drive(1'b1, 2, 32'h22, 4'b1111);
        drive(1'b0, 0, '0, 4'b1111);
        @(negedge clk);
        chk("bp second item", {32'd0, out_data[2]}, 64'h22);
        drive(1'b0, 0, '0, 4'hF);

        // Independence: channel 1 stalled full while channel 3 streams.
        drive(1'b1, 1, 32'h55, 4'b1101);
        for (int k = 0; k < 8; k++) drive(1'b1, 3, 32'h300 + 32'(k), 4'b1101);
        drive(1'b0, 0, '0, 4'b1101);
        @(negedge clk);
        chk("indep ch1 held", {32'd0, out_data[1]}, 64'h55);
        drive(1'b0, 0, '0, 4'hF);

        // Throughput: continuous stream to channel 0 (17 deliveries also wraps a 4-bit counter).
        for (int k = 0; k < 17; k++) drive(1'b1, 0, 32'h1000 + 32'(k), 4'hF);
        drive(1'b0, 0, '0, 4'hF);
        drive(1'b0, 0, '0, 4'hF);
`ifdef STREAM_DEMUX_CNT_EN
        @(negedge clk);
        chk("cnt wrap ch0", {60'd0, out_cnt[0]}, 64'(cnt_m[0]));
`endif

        // Randomised traffic with occasional mid-stream reset.
        for (int k = 0; k < 600; k++) begin
            drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, N-1)), DW'($urandom()),
                  4'($urandom()));
            if (k == 300) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                @(negedge clk);
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("midrst out_valid[%0d]", i), {63'd0, out_valid[i]}, 64'd0);
`ifdef STREAM_DEMUX_CNT_EN
                    chk($sformatf("midrst out_cnt[%0d]", i), {60'd0, out_cnt[i]}, 64'd0);
`endif
                end
            end
        end
        drive(1'b0, 0, '0, 4'hF);
        drive(1'b0, 0, '0, 4'hF);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
